rv32_mem_arbiter: RTL and testbench

- Shares one single-port memory bus between the instruction-fetch port and the mem-stage data port.
- Registers and sequences one transaction at a time.
- Arbitrates round-robin when both ports request.
- Returns read data, ready and fault to the winning port, and enforces a bus timeout that converts a hung access into a fault (data_fault_in / instr fault to the pipeline).

---
 rtl/rv32_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_rv32_mem_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: shares one single-port memory bus between the instruction
// fetch port and the mem-stage data port. One access is in flight at a time;
// contention is resolved round-robin, and a hung access is aborted with a
// fault after TIMEOUT_CYCLES wait cycles (0 disables the timeout).
module rv32_mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,

   // Instruction fetch port
   input  logic        instr_read_in,
   input  logic [31:0] instr_address_in,
   output logic        instr_ready_out,
   output logic [31:0] instr_read_value_out,
   output logic        instr_fault_out,

   // Data (load/store) port
   input  logic        data_read_in,
   input  logic        data_write_in,
   input  logic [31:0] data_address_in,
   input  logic [3:0]  data_write_mask_in,
   input  logic [31:0] data_write_value_in,
   output logic        data_ready_out,
   output logic [31:0] data_read_value_out,
   output logic        data_fault_out,

   // Shared memory bus
   output logic        mem_valid_out,
   output logic        mem_write_out,
   output logic [31:0] mem_address_out,
   output logic [3:0]  mem_write_mask_out,
   output logic [31:0] mem_write_value_out,
   input  logic        mem_ready_in,
   input  logic        mem_fault_in,
   input  logic [31:0] mem_read_value_in
);

   // A zero-width counter is not legal, so keep one bit when the timeout is off.
   localparam int unsigned CountWidth  =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam int unsigned TimeoutLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
   localparam logic [CountWidth-1:0] CountLast = CountWidth'(TimeoutLast);
   localparam bit TimeoutEn = (TIMEOUT_CYCLES > 0);

   typedef enum logic [1:0] {
      StIdle,
      StWaitInstr,
      StWaitData
   } state_e;

   typedef enum logic {
      GrantInstr,
      GrantData
   } grant_e;

   state_e                state;
   grant_e                last_grant;
   logic [CountWidth-1:0] timeout_count;

   logic                  data_req;
   logic                  in_wait;
   logic                  timed_out;
   logic                  complete;
   logic                  grant_data;
   logic [31:0]           resp_value;
   logic                  resp_fault;

   // Address bits [1:0] are word-aligned away before reaching the bus.
   logic                  unused_addr_bits;
   assign unused_addr_bits = ^{instr_address_in[1:0], data_address_in[1:0]};

   assign data_req  = data_read_in | data_write_in;
   assign in_wait   = (state != StIdle);

   // A real bus response always beats the timeout in the same cycle.
   assign timed_out = TimeoutEn && in_wait && !mem_ready_in && (timeout_count == CountLast);
   assign complete  = in_wait && (mem_ready_in || timed_out);

   // Round-robin pick used only in IDLE: on contention, the port that did not win last.
   always_comb begin
      grant_data = 1'b0;
      if (data_req && instr_read_in) begin
         grant_data = (last_grant == GrantInstr);
      end else begin
         grant_data = data_req;
      end
   end

   // Response payload: bus data and fault, or a zero-data fault on timeout.
   always_comb begin
      resp_value = '0;
      resp_fault = 1'b0;
      if (timed_out) begin
         resp_fault = 1'b1;
      end else if (mem_ready_in) begin
         resp_value = mem_read_value_in;
         resp_fault = mem_fault_in;
      end
   end

   // Route the response strobe to the owner of the current access only.
   always_comb begin
      instr_ready_out      = 1'b0;
      instr_read_value_out = '0;
      instr_fault_out      = 1'b0;
      data_ready_out       = 1'b0;
      data_read_value_out  = '0;
      data_fault_out       = 1'b0;
      if (complete) begin
         if (state == StWaitInstr) begin
            instr_ready_out      = 1'b1;
            instr_read_value_out = resp_value;
            instr_fault_out      = resp_fault;
         end else if (state == StWaitData) begin
            data_ready_out       = 1'b1;
            data_read_value_out  = resp_value;
            data_fault_out       = resp_fault;
         end
      end
   end

   // Transaction sequencer: grant in IDLE, hold the bus request in WAIT, release on completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state               <= StIdle;
         last_grant          <= GrantData;
         timeout_count       <= '0;
         mem_valid_out       <= 1'b0;
         mem_write_out       <= 1'b0;
         mem_address_out     <= '0;
         mem_write_mask_out  <= '0;
         mem_write_value_out <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (instr_read_in || data_req) begin
                  mem_valid_out <= 1'b1;
                  timeout_count <= '0;
                  if (grant_data) begin
                     state               <= StWaitData;
                     // A simultaneous read and write is issued as the write.
                     mem_write_out       <= data_write_in;
                     mem_address_out     <= {data_address_in[31:2], 2'b00};
                     mem_write_mask_out  <= data_write_in ? data_write_mask_in : 4'b0000;
                     mem_write_value_out <= data_write_in ? data_write_value_in : 32'd0;
                  end else begin
                     state               <= StWaitInstr;
                     mem_write_out       <= 1'b0;
                     mem_address_out     <= {instr_address_in[31:2], 2'b00};
                     mem_write_mask_out  <= 4'b0000;
                     mem_write_value_out <= 32'd0;
                  end
               end
            end
            StWaitInstr, StWaitData: begin
               if (complete) begin
                  state         <= StIdle;
                  mem_valid_out <= 1'b0;
                  last_grant    <= (state == StWaitData) ? GrantData : GrantInstr;
               end else if (TimeoutEn) begin
                  timeout_count <= timeout_count + CountWidth'(1);
               end
            end
            default: begin
               state         <= StIdle;
               mem_valid_out <= 1'b0;
            end
         endcase
      end
   end

   // The two response strobes are mutually exclusive.
   a_ready_onehot: assert property (@(posedge clk) disable iff (!reset)
      !(instr_ready_out && data_ready_out));

   // Bus request fields are frozen for the whole access.
   a_bus_stable: assert property (@(posedge clk) disable iff (!reset)
      (mem_valid_out && $past(mem_valid_out)) |->
         ($stable(mem_address_out) && $stable(mem_write_out) &&
          $stable(mem_write_mask_out) && $stable(mem_write_value_out)));

endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// Testbench for rv32_mem_arbiter: transaction-level reference model plus
// scoreboard. The stimulus process predicts bus requests and responses into
// queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_rv32_mem_arbiter;

   localparam int unsigned TO = 4;
   localparam bit PortInstr = 1'b0;
   localparam bit PortData  = 1'b1;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_read_in;
   logic [31:0] instr_address_in;
   logic        instr_ready_out;
   logic [31:0] instr_read_value_out;
   logic        instr_fault_out;
   logic        data_read_in;
   logic        data_write_in;
   logic [31:0] data_address_in;
   logic [3:0]  data_write_mask_in;
   logic [31:0] data_write_value_in;
   logic        data_ready_out;
   logic [31:0] data_read_value_out;
   logic        data_fault_out;
   logic        mem_valid_out;
   logic        mem_write_out;
   logic [31:0] mem_address_out;
   logic [3:0]  mem_write_mask_out;
   logic [31:0] mem_write_value_out;
   logic        mem_ready_in;
   logic        mem_fault_in;
   logic [31:0] mem_read_value_in;

   rv32_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk                  (clk),
      .reset                (reset),
      .instr_read_in        (instr_read_in),
      .instr_address_in     (instr_address_in),
      .instr_ready_out      (instr_ready_out),
      .instr_read_value_out (instr_read_value_out),
      .instr_fault_out      (instr_fault_out),
      .data_read_in         (data_read_in),
      .data_write_in        (data_write_in),
      .data_address_in      (data_address_in),
      .data_write_mask_in   (data_write_mask_in),
      .data_write_value_in  (data_write_value_in),
      .data_ready_out       (data_ready_out),
      .data_read_value_out  (data_read_value_out),
      .data_fault_out       (data_fault_out),
      .mem_valid_out        (mem_valid_out),
      .mem_write_out        (mem_write_out),
      .mem_address_out      (mem_address_out),
      .mem_write_mask_out   (mem_write_mask_out),
      .mem_write_value_out  (mem_write_value_out),
      .mem_ready_in         (mem_ready_in),
      .mem_fault_in         (mem_fault_in),
      .mem_read_value_in    (mem_read_value_in)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      logic        write;
      logic [3:0]  mask;
      logic [31:0] value;
      int          cyc;
   } bus_t;

   typedef struct {
      bit          port;
      logic [31:0] data;
      logic        fault;
      int          cyc;
   } resp_t;

   typedef struct {
      int          lat;
      bit          fault;
      logic [31:0] rdata;
   } plan_t;

   bus_t  exp_bus[$];
   resp_t exp_resp[$];
   plan_t plan_q[$];

   int vectors     = 0;
   int miscompares = 0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // ---------------- monitor ----------------
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      resp_t       e;
      bus_t        b;
      logic [31:0] act_data;
      logic        act_fault;
      if (!reset) begin
         prev_valid <= 1'b0;
      end else begin
         if (instr_ready_out || data_ready_out) begin
            check("ready_exclusive", 32'(instr_ready_out & data_ready_out), 32'd0);
            if (exp_resp.size() == 0) begin
               check("unexpected_ready", 32'(instr_ready_out | data_ready_out), 32'd0);
            end else begin
               e         = exp_resp.pop_front();
               act_data  = data_ready_out ? data_read_value_out : instr_read_value_out;
               act_fault = data_ready_out ? data_fault_out : instr_fault_out;
               check("resp_port", 32'(data_ready_out), 32'(e.port));
               check("resp_cycle", 32'(cyc), 32'(e.cyc));
               check("resp_data", act_data, e.data);
               check("resp_fault", 32'(act_fault), 32'(e.fault));
            end
         end else if (exp_resp.size() > 0 && exp_resp[0].cyc <= cyc) begin
            e = exp_resp.pop_front();
            check("resp_missing", 32'(instr_ready_out | data_ready_out), 32'd1);
         end

         if (mem_valid_out && !prev_valid) begin
            if (exp_bus.size() == 0) begin
               check("unexpected_bus_req", 32'(mem_valid_out), 32'd0);
            end else begin
               b = exp_bus.pop_front();
               check("bus_cycle", 32'(cyc), 32'(b.cyc));
               check("bus_addr", mem_address_out, b.addr);
               check("bus_write", 32'(mem_write_out), 32'(b.write));
               check("bus_mask", 32'(mem_write_mask_out), 32'(b.mask));
               if (b.write) check("bus_wvalue", mem_write_value_out, b.value);
            end
         end else if (exp_bus.size() > 0 && exp_bus[0].cyc <= cyc) begin
            b = exp_bus.pop_front();
            check("bus_req_missing", 32'(mem_valid_out && !prev_valid), 32'd1);
         end
         prev_valid <= mem_valid_out;
      end
   end

   // ---------------- reference model and stimulus ----------------
   int    p_new   = 0;
   int    p_flush = 0;
   bit    i_infl  = 0, d_infl = 0, i_done = 0, d_done = 0;
   bit    m_busy  = 0;
   bit    m_port  = PortInstr;
   bit    m_last  = PortData;
   int    m_k     = 0;
   plan_t m_plan;

   task automatic add_plan(input int lat, input bit fault, input logic [31:0] rdata);
      plan_t p;
      p.lat = lat; p.fault = fault; p.rdata = rdata;
      plan_q.push_back(p);
   endtask

   task automatic new_data();
      int kind;
      kind                = int'($urandom_range(2));
      data_read_in        = (kind != 1);
      data_write_in       = (kind != 0);
      data_address_in     = $urandom;
      data_write_mask_in  = 4'($urandom);
      data_write_value_in = $urandom;
   endtask

   // One clock cycle: requesters act, the model predicts, then advance to posedge+1.
   task automatic step();
      bit    rdy, tmo, w;
      resp_t r;
      bus_t  b;
      if (i_done) begin instr_read_in = 1'b0; i_done = 0; end
      if (d_done) begin data_read_in = 1'b0; data_write_in = 1'b0; d_done = 0; end
      if (!instr_read_in && !i_infl && int'($urandom_range(99)) < p_new) begin
         instr_read_in    = 1'b1;
         instr_address_in = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_read_in && !data_write_in && !d_infl && int'($urandom_range(99)) < p_new)
         new_data();
      // Pipeline flush: drop a request whose access is already on the bus.
      if (instr_read_in && i_infl && int'($urandom_range(99)) < p_flush) instr_read_in = 1'b0;
      if ((data_read_in || data_write_in) && d_infl && int'($urandom_range(99)) < p_flush) begin
         data_read_in  = 1'b0;
         data_write_in = 1'b0;
      end

      if (m_busy) begin
         rdy = (m_k == m_plan.lat);
         tmo = (TO > 0) && !rdy && (m_k == int'(TO) - 1);
         mem_ready_in      = rdy;
         mem_fault_in      = rdy ? m_plan.fault : 1'($urandom);
         mem_read_value_in = rdy ? m_plan.rdata : $urandom;
         if (rdy || tmo) begin
            r.port  = m_port;
            r.data  = rdy ? m_plan.rdata : 32'd0;
            r.fault = rdy ? m_plan.fault : 1'b1;
            r.cyc   = cyc;
            exp_resp.push_back(r);
            m_busy = 0;
            m_last = m_port;
            if (m_port == PortData) begin d_infl = 0; d_done = 1; end
            else begin i_infl = 0; i_done = 1; end
         end else begin
            m_k++;
         end
      end else begin
         // Bus noise while idle must be ignored.
         mem_ready_in      = (int'($urandom_range(99)) < 20);
         mem_fault_in      = 1'($urandom);
         mem_read_value_in = $urandom;
         if (instr_read_in || data_read_in || data_write_in) begin
            if (instr_read_in && (data_read_in || data_write_in))
               w = (m_last == PortData) ? PortInstr : PortData;
            else
               w = (data_read_in || data_write_in) ? PortData : PortInstr;
            if (w == PortData) begin
               b.addr  = data_address_in & 32'hFFFF_FFFC;
               b.write = data_write_in;
               b.mask  = data_write_in ? data_write_mask_in : 4'b0000;
               b.value = data_write_value_in;
               d_infl  = 1;
            end else begin
               b.addr  = instr_address_in & 32'hFFFF_FFFC;
               b.write = 1'b0;
               b.mask  = 4'b0000;
               b.value = 32'd0;
               i_infl  = 1;
            end
            b.cyc = cyc + 1;
            exp_bus.push_back(b);
            m_busy = 1;
            m_port = w;
            m_k    = 0;
            if (plan_q.size() > 0) begin
               m_plan = plan_q.pop_front();
            end else begin
               m_plan.lat   = int'($urandom_range(5));
               m_plan.fault = (int'($urandom_range(99)) < 15);
               m_plan.rdata = $urandom;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_until_quiet(input int limit);
      bit quiet;
      quiet = 0;
      for (int n = 0; n < limit && !quiet; n++) begin
         step();
         quiet = !m_busy && !i_done && !d_done && !instr_read_in && !data_read_in &&
                 !data_write_in;
      end
      if (!quiet) check("drain_timeout", 32'(m_busy), 32'd0);
   endtask

   initial begin
      reset               = 1'b0;
      instr_read_in       = 1'b0;
      instr_address_in    = '0;
      data_read_in        = 1'b0;
      data_write_in       = 1'b0;
      data_address_in     = '0;
      data_write_mask_in  = '0;
      data_write_value_in = '0;
      mem_ready_in        = 1'b0;
      mem_fault_in        = 1'b0;
      mem_read_value_in   = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_mem_valid", 32'(mem_valid_out), 32'd0);
      check("rst_mem_write", 32'(mem_write_out), 32'd0);
      check("rst_mem_addr", mem_address_out, 32'd0);
      check("rst_mem_mask", 32'(mem_write_mask_out), 32'd0);
      check("rst_mem_wvalue", mem_write_value_out, 32'd0);
      check("rst_instr_ready", 32'(instr_ready_out), 32'd0);
      check("rst_instr_fault", 32'(instr_fault_out), 32'd0);
      check("rst_instr_value", instr_read_value_out, 32'd0);
      check("rst_data_ready", 32'(data_ready_out), 32'd0);
      check("rst_data_fault", 32'(data_fault_out), 32'd0);
      check("rst_data_value", data_read_value_out, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single load
      add_plan(0, 1'b0, 32'hDEAD_BEEF);
      data_read_in    = 1'b1;
      data_address_in = 32'h0000_0100;
      run_until_quiet(20);

      // Store with three wait cycles, unaligned address
      add_plan(3, 1'b0, 32'h0);
      data_write_in       = 1'b1;
      data_write_mask_in  = 4'b0100;
      data_write_value_in = 32'h00AB_0000;
      data_address_in     = 32'h0000_0203;
      run_until_quiet(20);

      // Bus fault on a load
      add_plan(0, 1'b1, 32'hCAFE_F00D);
      data_read_in    = 1'b1;
      data_address_in = 32'h0000_0300;
      run_until_quiet(20);

      // Hung fetch times out, then the pending load is served
      add_plan(50, 1'b0, 32'h0);
      add_plan(1, 1'b0, 32'h1234_5678);
      instr_read_in    = 1'b1;
      instr_address_in = 32'h0000_0400;
      data_read_in     = 1'b1;
      data_address_in  = 32'h0000_0500;
      run_until_quiet(30);

      // Reset in the middle of a data access
      add_plan(50, 1'b0, 32'h0);
      data_read_in    = 1'b1;
      data_address_in = 32'h0000_0600;
      step();
      step();
      mem_ready_in = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("midrst_mem_valid", 32'(mem_valid_out), 32'd0);
      check("midrst_data_ready", 32'(data_ready_out), 32'd0);
      check("midrst_instr_ready", 32'(instr_ready_out), 32'd0);
      data_read_in = 1'b0;
      m_busy = 0; m_last = PortData; i_infl = 0; d_infl = 0; i_done = 0; d_done = 0;
      plan_q.delete();
      @(negedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Continuous contention from both ports: instr first after reset
      p_new            = 100;
      instr_read_in    = 1'b1;
      instr_address_in = 32'h0000_0700;
      data_read_in     = 1'b1;
      data_address_in  = 32'h0000_0800;
      repeat (40) step();

      // Random traffic with flushes
      p_flush = 10;
      p_new   = 50;
      repeat (800) step();

      p_new   = 0;
      p_flush = 0;
      run_until_quiet(100);
      repeat (2) step();

      check("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
      check("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
      check("final_mem_valid", 32'(mem_valid_out), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
